bcd_operand_loader: RTL and testbench
=====================================

# bcd_operand_loader

Digit-serial front end for the 100-digit BCD adder. It accepts BCD digits one per cycle over a valid/ready stream, least-significant digit first, and assembles operand A, then operand B plus carry-in. It presents the packed 400-bit operands with a valid/ready handshake to the parallel adder stage. Non-BCD digits are flagged.

## Interface

Parameters:
- DIGITS, 100: digits per operand. Operand width is 4*DIGITS.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  in_digit, in_last and in_cin are valid this cycle.
- in_ready  out  1  loader accepts a digit this cycle.
- in_digit  in  4  BCD digit.
- in_last  in  1  this digit is the final, most-significant digit of the current operand.
- in_cin  in  1  carry-in; sampled only on the last digit of B.
- a  out  4*DIGITS  packed operand A; digit k sits at bits [4k+3:4k].
- b  out  4*DIGITS  packed operand B, same packing.
- cin  out  1  carry-in for the adder.
- out_valid  out  1  a, b, cin and err form a complete pair.
- out_ready  in  1  adder stage consumes the pair.
- err  out  1  at least one digit of the pair was greater than 9.

## Operation

- A "digit handshake" is in_valid && in_ready.
- A "transfer" is out_valid && out_ready.

States:
- LOAD_A: in_ready=1. On a digit handshake, the digit is written to A slot idx and idx increments. The operand ends when in_last=1 or idx==DIGITS-1; then idx clears and the state moves to LOAD_B.
- LOAD_B: same behaviour, writing B. At operand end, cin is set to in_cin and the state moves to HOLD.
- HOLD: in_ready=0 and out_valid=1. On a transfer, a, b, cin, err and idx all clear, and the state moves to LOAD_A.

Digit and counter rules:
- Short operands are allowed. Unwritten upper digits stay 0 because registers are cleared at reset and on each transfer.
- A digit greater than 9 (0xA–0xF) is stored as 0 and sets err. err is sticky until the transfer.
- idx is ceil(log2(DIGITS)) bits. It never wraps, because reaching DIGITS-1 forces operand end. in_last at that index is ignored.

Other behaviour:
- in_valid with in_ready=0 (HOLD) has no effect. Upstream must hold its data.
- A mid-load reset clears everything and returns to LOAD_A. The partial operand is discarded.

## Timing

- Reset values: in_ready=1 and state=LOAD_A. out_valid, err and cin are 0. a and b are all zero.
- Throughput: one digit per cycle while loading.
- out_valid rises on the edge that accepts B's final digit. It is visible the following cycle.
- Once out_valid is asserted:
  - it stays high, with a, b, cin and err stable, until out_ready is seen;
  - the transfer edge drops out_valid and raises in_ready in the same edge.
- Minimum pair period is 2 + 1 cycles for single-digit operands: A digit, B digit, then one HOLD cycle with out_ready=1.
- out_ready has no combinational path to in_ready. in_ready is a registered state decode.

## Structure

Shared package:
- DIGITS default
- BCD_W=4
- state enum {LOAD_A, LOAD_B, HOLD}
- function is_bcd(digit)

Sub-module: bcd_operand_reg, instantiated twice for A and B.
- Inputs: write enable, index, digit, clear.
- Contents: a 4*DIGITS register with indexed digit write, returning the digit-valid flag.
- The FSM, counter and err live in the top.

## Test plan

- Reset during a LOAD_A load of 37 digits → a=0, in_ready=1, out_valid=0, err=0; a following clean load works.
- A digits 1,2,3 (last on 3) and B digits 9,9 (last on second), in_cin=1, out_ready=1 → out_valid one cycle later with a[11:0]=0x321, b[7:0]=0x99, all upper bits 0, cin=1, err=0.
- 100 A digits all 9 with in_last never asserted → state moves to LOAD_B after the 100th digit and a is all 0x9. Then 100 B digits of 0 with cin=1 → b=0, cin=1.
- A digit 0xC inside operand B → that slot reads 0 and err=1 at out_valid. err clears after the transfer.
- Hold out_ready=0 for 5 cycles while in_valid=1 → in_ready=0 and a, b, cin are stable. Assert out_ready → transfer, and in_ready=1 the next cycle.
- Back-to-back pairs with out_ready tied high → no digit lost, and the second pair's upper digits are zero despite the longer first pair.

Source files
------------

// File: rtl/bcd_operand_loader_pkg.sv
// Shared types and helpers for the digit-serial BCD operand loader.
package bcd_operand_loader_pkg;

    localparam int unsigned DIGITS_DEF = 100;
    localparam int unsigned BCD_W      = 4;

    typedef enum logic [1:0] {
        LOAD_A,
        LOAD_B,
        HOLD
    } state_e;

    function automatic logic is_bcd(input logic [BCD_W-1:0] digit);
        return digit <= 4'd9;
    endfunction

endpackage

// File: rtl/bcd_operand_loader_if.sv
// Digit stream in, packed operand pair out; slave is the loader, master its environment.
interface bcd_operand_loader_if
    import bcd_operand_loader_pkg::*;
#(
    parameter int unsigned DIGITS = DIGITS_DEF
);
    logic                    in_valid;
    logic                    in_ready;
    logic [BCD_W-1:0]        in_digit;
    logic                    in_last;
    logic                    in_cin;
    logic [BCD_W*DIGITS-1:0] a;
    logic [BCD_W*DIGITS-1:0] b;
    logic                    cin;
    logic                    out_valid;
    logic                    out_ready;
    logic                    err;

    modport slave (
        input  in_valid, in_digit, in_last, in_cin, out_ready,
        output in_ready, a, b, cin, out_valid, err
    );

    modport master (
        output in_valid, in_digit, in_last, in_cin, out_ready,
        input  in_ready, a, b, cin, out_valid, err
    );
endinterface

// File: rtl/bcd_operand_reg.sv
// One packed BCD operand with indexed digit write; non-BCD digits are stored as zero.
module bcd_operand_reg
    import bcd_operand_loader_pkg::*;
#(
    parameter  int unsigned DIGITS = DIGITS_DEF,
    localparam int unsigned IDX_W  = (DIGITS > 1) ? $clog2(DIGITS) : 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    we_i,
    input  logic [IDX_W-1:0]        idx_i,
    input  logic [BCD_W-1:0]        digit_i,
    input  logic                    clr_i,
    output logic [BCD_W*DIGITS-1:0] data_o,
    output logic                    digit_ok_o
);
    logic [BCD_W*DIGITS-1:0] data_q;
    logic [BCD_W*DIGITS-1:0] data_d;

    assign digit_ok_o = is_bcd(digit_i);
    assign data_o     = data_q;

    always_comb begin
        data_d = data_q;
        if (clr_i) begin
            data_d = '0;
        end else if (we_i) begin
            data_d[idx_i*BCD_W +: BCD_W] = digit_ok_o ? digit_i : '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q <= '0;
        end else begin
            data_q <= data_d;
        end
    end
endmodule

// File: rtl/bcd_operand_loader.sv
// Assembles operand A, then B plus carry-in, from a digit stream and holds the pair for the adder.
module bcd_operand_loader
    import bcd_operand_loader_pkg::*;
#(
    parameter  int unsigned DIGITS = DIGITS_DEF,
    localparam int unsigned IDX_W  = (DIGITS > 1) ? $clog2(DIGITS) : 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    bcd_operand_loader_if.slave  bus
);
    state_e           state_q;
    logic [IDX_W-1:0] idx_q;
    logic             err_q;
    logic             cin_q;
    logic             in_ready_q;
    logic             out_valid_q;

    logic hs;
    logic xfer;
    logic op_end;
    logic we_a;
    logic we_b;
    logic ok_a;
    logic ok_b;
    logic digit_ok;

    assign hs       = bus.in_valid && in_ready_q;
    assign xfer     = out_valid_q && bus.out_ready;
    // The top slot forces operand end so idx never wraps, regardless of in_last.
    assign op_end   = bus.in_last || (idx_q == IDX_W'(DIGITS - 1));
    assign we_a     = hs && (state_q == LOAD_A);
    assign we_b     = hs && (state_q == LOAD_B);
    assign digit_ok = (state_q == LOAD_B) ? ok_b : ok_a;

    bcd_operand_reg #(.DIGITS(DIGITS)) u_reg_a (
        .clk        (clk),
        .rst_n      (rst_n),
        .we_i       (we_a),
        .idx_i      (idx_q),
        .digit_i    (bus.in_digit),
        .clr_i      (xfer),
        .data_o     (bus.a),
        .digit_ok_o (ok_a)
    );

    bcd_operand_reg #(.DIGITS(DIGITS)) u_reg_b (
        .clk        (clk),
        .rst_n      (rst_n),
        .we_i       (we_b),
        .idx_i      (idx_q),
        .digit_i    (bus.in_digit),
        .clr_i      (xfer),
        .data_o     (bus.b),
        .digit_ok_o (ok_b)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= LOAD_A;
            idx_q       <= '0;
            err_q       <= 1'b0;
            cin_q       <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            case (state_q)
                LOAD_A: begin
                    if (hs) begin
                        if (!digit_ok) err_q <= 1'b1;
                        if (op_end) begin
                            idx_q   <= '0;
                            state_q <= LOAD_B;
                        end else begin
                            idx_q <= idx_q + 1'b1;
                        end
                    end
                end
                LOAD_B: begin
                    if (hs) begin
                        if (!digit_ok) err_q <= 1'b1;
                        if (op_end) begin
                            idx_q       <= '0;
                            cin_q       <= bus.in_cin;
                            state_q     <= HOLD;
                            in_ready_q  <= 1'b0;
                            out_valid_q <= 1'b1;
                        end else begin
                            idx_q <= idx_q + 1'b1;
                        end
                    end
                end
                HOLD: begin
                    if (xfer) begin
                        idx_q       <= '0;
                        err_q       <= 1'b0;
                        cin_q       <= 1'b0;
                        state_q     <= LOAD_A;
                        in_ready_q  <= 1'b1;
                        out_valid_q <= 1'b0;
                    end
                end
                default: begin
                    state_q     <= LOAD_A;
                    idx_q       <= '0;
                    in_ready_q  <= 1'b1;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.err       = err_q;
    assign bus.cin       = cin_q;
endmodule

// File: tb/tb_bcd_operand_loader.sv
// Randomized and directed pairs checked against a queue-based operand model.
module tb_bcd_operand_loader;
    import bcd_operand_loader_pkg::*;

    localparam int unsigned D = 100;
    localparam int unsigned W = 4 * D;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    bcd_operand_loader_if #(.DIGITS(D)) bus ();

    bcd_operand_loader #(.DIGITS(D)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int unsigned vectors     = 0;
    int unsigned miscompares = 0;

    task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Expected packed operand: digit i at nibble i, non-BCD digits read as zero.
    function automatic logic [W-1:0] pack(input logic [3:0] q[$]);
        logic [W-1:0] r = '0;
        foreach (q[i]) r[i*4 +: 4] = (q[i] > 4'd9) ? 4'd0 : q[i];
        return r;
    endfunction

    function automatic logic any_bad(input logic [3:0] q[$]);
        foreach (q[i]) if (q[i] > 4'd9) return 1'b1;
        return 1'b0;
    endfunction

    task automatic push(input logic [3:0] d, input logic last, input logic c);
        int unsigned n = 0;
        bus.in_valid = 1'b1;
        bus.in_digit = d;
        bus.in_last  = last;
        bus.in_cin   = c;
        while (!bus.in_ready && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        if (!bus.in_ready) chk("in_ready_timeout", W'(0), W'(1));
        @(posedge clk); #1;
    endtask

    task automatic load(input logic [3:0] q[$], input logic use_last, input logic c);
        foreach (q[i]) begin
            if (i == q.size() - 1) push(q[i], use_last, c);
            else push(q[i], 1'b0, 1'($urandom_range(0, 1)));
        end
        bus.in_valid = 1'b0;
    endtask

    task automatic pair(input logic [3:0] qa[$], input logic [3:0] qb[$], input logic la,
                        input logic lb, input logic c, input int unsigned hold, input logic tied);
        logic [W-1:0] ea;
        logic [W-1:0] eb;
        logic         ee;
        ea = pack(qa);
        eb = pack(qb);
        ee = any_bad(qa) || any_bad(qb);
        bus.out_ready = tied;
        load(qa, la, 1'($urandom_range(0, 1)));
        chk("a_done_in_ready", W'(bus.in_ready), W'(1));
        chk("a_done_out_valid", W'(bus.out_valid), W'(0));
        load(qb, lb, c);
        chk("out_valid", W'(bus.out_valid), W'(1));
        chk("hold_in_ready", W'(bus.in_ready), W'(0));
        chk("a", bus.a, ea);
        chk("b", bus.b, eb);
        chk("cin", W'(bus.cin), W'(c));
        chk("err", W'(bus.err), W'(ee));
        if (!tied) begin
            repeat (hold) begin
                bus.in_valid = 1'b1;
                bus.in_digit = 4'($urandom);
                bus.in_last  = 1'($urandom);
                bus.in_cin   = 1'($urandom);
                @(posedge clk); #1;
                chk("stall_in_ready", W'(bus.in_ready), W'(0));
                chk("stall_out_valid", W'(bus.out_valid), W'(1));
                chk("stall_a", bus.a, ea);
                chk("stall_b", bus.b, eb);
                chk("stall_cin", W'(bus.cin), W'(c));
                chk("stall_err", W'(bus.err), W'(ee));
            end
            bus.in_valid  = 1'b0;
            bus.out_ready = 1'b1;
        end
        @(posedge clk); #1;
        bus.out_ready = tied;
        chk("xfer_out_valid", W'(bus.out_valid), W'(0));
        chk("xfer_in_ready", W'(bus.in_ready), W'(1));
        chk("xfer_a", bus.a, W'(0));
        chk("xfer_b", bus.b, W'(0));
        chk("xfer_cin", W'(bus.cin), W'(0));
        chk("xfer_err", W'(bus.err), W'(0));
    endtask

    function automatic void rand_operand(output logic [3:0] q[$], input int unsigned len);
        q.delete();
        for (int unsigned i = 0; i < len; i++) begin
            if ($urandom_range(0, 19) == 0) q.push_back(4'($urandom_range(10, 15)));
            else q.push_back(4'($urandom_range(0, 9)));
        end
    endfunction

    initial begin
        logic [3:0] qa[$];
        logic [3:0] qb[$];
        logic       la;
        logic       lb;
        int unsigned len_a;
        int unsigned len_b;

        bus.in_valid  = 1'b0;
        bus.in_digit  = '0;
        bus.in_last   = 1'b0;
        bus.in_cin    = 1'b0;
        bus.out_ready = 1'b0;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        chk("rst_in_ready", W'(bus.in_ready), W'(1));
        chk("rst_out_valid", W'(bus.out_valid), W'(0));
        chk("rst_err", W'(bus.err), W'(0));
        chk("rst_cin", W'(bus.cin), W'(0));
        chk("rst_a", bus.a, W'(0));
        chk("rst_b", bus.b, W'(0));

        // Reset in the middle of a 37-digit A load, including some bad digits.
        for (int i = 0; i < 37; i++) push(4'($urandom_range(0, 15)), 1'b0, 1'b0);
        bus.in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("midrst_a", bus.a, W'(0));
        chk("midrst_in_ready", W'(bus.in_ready), W'(1));
        chk("midrst_out_valid", W'(bus.out_valid), W'(0));
        chk("midrst_err", W'(bus.err), W'(0));
        @(posedge clk); #1;
        rst_n = 1'b1;

        qa = '{4'd1, 4'd2, 4'd3};
        qb = '{4'd9, 4'd9};
        pair(qa, qb, 1'b1, 1'b1, 1'b1, 0, 1'b0);

        // Full-length operands with in_last never asserted.
        qa.delete();
        qb.delete();
        for (int i = 0; i < D; i++) begin
            qa.push_back(4'd9);
            qb.push_back(4'd0);
        end
        pair(qa, qb, 1'b0, 1'b0, 1'b1, 1, 1'b0);

        qa = '{4'd4, 4'd5};
        qb = '{4'd5, 4'hC, 4'd7};
        pair(qa, qb, 1'b1, 1'b1, 1'b0, 0, 1'b0);

        qa = '{4'd8};
        qb = '{4'd6};
        pair(qa, qb, 1'b1, 1'b1, 1'b1, 5, 1'b0);

        // Back-to-back with out_ready tied high: long pair, then short one.
        rand_operand(qa, 60);
        rand_operand(qb, 71);
        pair(qa, qb, 1'b1, 1'b1, 1'b0, 0, 1'b1);
        rand_operand(qa, 1);
        rand_operand(qb, 2);
        pair(qa, qb, 1'b1, 1'b1, 1'b1, 0, 1'b1);

        for (int t = 0; t < 25; t++) begin
            len_a = ($urandom_range(0, 3) == 0) ? $urandom_range(1, D) : $urandom_range(1, 12);
            len_b = ($urandom_range(0, 3) == 0) ? $urandom_range(1, D) : $urandom_range(1, 12);
            rand_operand(qa, len_a);
            rand_operand(qb, len_b);
            la = (len_a == D) ? 1'($urandom_range(0, 1)) : 1'b1;
            lb = (len_b == D) ? 1'($urandom_range(0, 1)) : 1'b1;
            pair(qa, qb, la, lb, 1'($urandom_range(0, 1)), $urandom_range(0, 3),
                 1'($urandom_range(0, 1)));
        end
        bus.out_ready = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
